dmux8_dispatch_ctrl: RTL and testbench
======================================

Name: dmux8_dispatch_ctrl

Overview:
Round-robin dispatcher that routes a single valid/ready word stream to one of 8 destinations over a shared data bus with a one-hot valid. It holds a one-entry buffer, grants one destination at a time, and keeps that grant for a burst of up to BURST_LEN words before rotating. It sits in front of the 1-to-8 demux datapath and generates its select and enable sequencing.

Parameters:
DATA_W, 8, width of in_data/out_data
BURST_LEN, 4, max words sent to one destination per grant (legal range 1..255)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream word valid
in_data  input  DATA_W  upstream word
in_ready  output  1  upstream may transfer (combinational)
en_mask  input  8  per-destination enable; 0 = never grant
out_ready  input  8  per-destination ready
out_valid  output  8  one-hot or zero; bit sel asserted when the word is offered
out_data  output  DATA_W  shared bus, always equals buffer contents
sel  output  3  current/last granted destination index
busy  output  1  high while a grant is held (state SEND)

Behaviour:
- Reset (async, rst=1): state=IDLE, buf_valid=0, buf_data=0, sel=0, ptr=7 (first search starts at 0), cnt=0.
- Reset outputs: out_valid=0, busy=0, sel=0, out_data=0, in_ready=1.
- Buffer: in_xfer = in_valid & in_ready; out_xfer = (state==SEND) & buf_valid & out_ready[sel].
- in_ready = !buf_valid | out_xfer; simultaneous in/out transfer keeps buf_valid=1 with new data.
- out_valid = (state==SEND & buf_valid) ? (1<<sel) : 0.
- States: IDLE, SEND.
- IDLE: when buf_valid, elig = en_mask & out_ready.
  - Search elig round-robin from ptr+1 mod 8 upward with wrap.
  - On hit, next edge: sel=idx, cnt=0, state=SEND.
  - On no hit, stay IDLE; buffer held.
  - No arbitration while buf empty.
- SEND:
  - Each out_xfer increments cnt.
  - Return to IDLE with ptr=sel when any of the following holds:
    - out_xfer with cnt==BURST_LEN-1
    - en_mask[sel]==0 (after completing any same-cycle out_xfer)
  - out_ready[sel] low does not end the grant; the controller waits indefinitely.
  - Buffer empty in SEND: grant held, out_valid=0, cnt unchanged.
- Latency: word accepted at edge t into an empty buffer while in SEND reaches out_valid at t+1. In IDLE it is offered at t+2 (one arbitration cycle).
- Burst throughput: 1 word/clk while in_valid and out_ready[sel] are both held high.
- BURST_LEN=1: rotate after every word.
- Wrap: ptr=7 search order is 0,1,…,7; ptr=3 search order is 4,…,7,0,…,3 (self last).
- Reset mid-burst: buffered word is discarded, outputs return to reset values immediately.
- out_data stays stable while out_valid is high and not accepted (buffer only loads on in_xfer).

Decomposition:
- Package dmux8_ctrl_pkg holds:
  - N_DEST=8 and SEL_W=3
  - state_t enum {IDLE, SEND}
  - function onehot8(sel)
- Sub-module rr_pick8, purely combinational:
  - inputs req[7:0], ptr[2:0]
  - outputs found, idx[2:0]
  - first set bit searching from ptr+1 with wrap

Test Plan:
- Reset then stream 0x10..0x17, all en_mask/out_ready=0xFF, BURST_LEN=4: words 0x10-0x13 go to out_valid=0x01, then 0x14-0x17 to 0x02. Exactly one IDLE bubble at the switch; sel=0 then 1.
- en_mask=0x84, continuous stream: grants alternate dest 2 then 7, wrap 7→2. out_valid only 0x04/0x80; never any other bit.
- Grant on dest 3, drop out_ready[3] for 5 cycles mid-burst: out_valid=0x08 held, out_data stable, in_ready=0 once the buffer is full. No data loss; burst resumes and finishes 4 words.
- Clear en_mask[5] while dest 5 holds a word with out_ready[5]=0: next cycle state IDLE. The same word is re-granted to the next eligible dest (e.g. 6), ptr=5.
- Assert rst asynchronously mid-burst with buf_valid=1: out_valid=0, busy=0, in_ready=1, sel=0 before the next clk edge. After release, the first grant goes to dest 0.

Source files
------------

// File: rtl/dmux8_ctrl_pkg.sv
// Shared types and helpers for the 8-way round-robin dispatch controller.
package dmux8_ctrl_pkg;

  localparam int N_DEST = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // One-hot decode of a destination index.
  function automatic logic [N_DEST-1:0] onehot8(input logic [SEL_W-1:0] sel);
    logic [N_DEST-1:0] r;
    r      = '0;
    r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dmux8_dispatch_ctrl_rr_pick8.sv
// Combinational round-robin picker: first set request bit starting at
// ptr+1 and wrapping, so the previously granted index is searched last.
module rr_pick8
  import dmux8_ctrl_pkg::*;
(
  input  logic [N_DEST-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] cand [N_DEST];

  // Candidate index for each search position; position 7 wraps back to ptr.
  for (genvar gi = 0; gi < N_DEST; gi++) begin : g_cand
    assign cand[gi] = ptr + SEL_W'(gi + 1);
  end

  // Walk from the lowest-priority position down so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_DEST - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        found = 1'b1;
        idx   = cand[i];
      end
    end
  end

endmodule

// File: rtl/dmux8_dispatch_ctrl.sv
// Round-robin dispatcher: one-entry buffer feeding 8 destinations over a
// shared data bus, holding each grant for up to BURST_LEN words.
module dmux8_dispatch_ctrl
  import dmux8_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [N_DEST-1:0] en_mask,
  input  logic [N_DEST-1:0] out_ready,
  output logic [N_DEST-1:0] out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
);

  localparam logic [7:0] CNT_LAST = 8'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic              buf_valid_q, buf_valid_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              in_xfer, out_xfer;
  logic              pick_found;
  logic [SEL_W-1:0]  pick_idx;

  assign out_xfer  = (state_q == SEND) && buf_valid_q && out_ready[sel_q];
  assign in_ready  = !buf_valid_q || out_xfer;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = ((state_q == SEND) && buf_valid_q) ? onehot8(sel_q) : '0;
  assign out_data  = buf_data_q;
  assign sel       = sel_q;
  assign busy      = (state_q == SEND);

  rr_pick8 u_pick (
    .req   (en_mask & out_ready),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Buffer: a new word replaces the old one even when both transfer together.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (in_xfer) begin
      buf_valid_d = 1'b1;
      buf_data_d  = in_data;
    end else if (out_xfer) begin
      buf_valid_d = 1'b0;
    end
  end

  // Grant FSM: arbitrate only with a word waiting; release on burst end or disable.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (buf_valid_q && pick_found) begin
          sel_d   = pick_idx;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_xfer) begin
          cnt_d = cnt_q + 8'd1;
        end
        if ((out_xfer && (cnt_q == CNT_LAST)) || !en_mask[sel_q]) begin
          state_d = IDLE;
          ptr_d   = sel_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; ptr resets to 7 so the first search begins at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      sel_q       <= '0;
      ptr_q       <= SEL_W'(N_DEST - 1);
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmux8_dispatch_ctrl.sv
// Directed bench for the round-robin dispatch controller.
module tb_dmux8_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] en_mask;
  logic [7:0] out_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] log_ov [64];
  logic [7:0] log_od [64];
  int nlog;
  int bubbles;
  int illegal;

  always #5 clk = ~clk;

  dmux8_dispatch_ctrl #(.DATA_W(8), .BURST_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .en_mask   (en_mask),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    en_mask   = 8'h00;
    out_ready = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Feed n words from base, log every output transfer until nexp are seen.
  task automatic run_stream(input int n, input logic [7:0] base, input int nexp,
                            input logic [7:0] allowed);
    int sent = 0;
    int cyc  = 0;
    int gap  = 0;
    nlog    = 0;
    bubbles = 0;
    illegal = 0;
    while (nlog < nexp && cyc < 200) begin
      in_valid = (sent < n);
      in_data  = base + 8'(sent);
      #1;
      if ((out_valid & ~allowed) != 8'h00) illegal++;
      if ((out_valid & out_ready) != 8'h00) begin
        if (nlog > 0) bubbles += gap;
        gap = 0;
        log_ov[nlog] = out_valid;
        log_od[nlog] = out_data;
        nlog++;
      end else if (nlog > 0) begin
        gap++;
      end
      if (in_valid && in_ready) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_xfer_count", nlog, nexp);
  endtask

  initial begin
    int bad;

    // Reset values
    reset_dut();
    #1;
    chk("rst_out_valid", out_valid, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sel", sel, 3'd0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_in_ready", in_ready, 1'b1);

    // Stream 0x10..0x17, all enabled: 4 words to dest 0, one bubble, 4 to dest 1
    reset_dut();
    en_mask   = 8'hFF;
    out_ready = 8'hFF;
    run_stream(8, 8'h10, 8, 8'h03);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_ov[%0d]", i), log_ov[i], (i < 4) ? 8'h01 : 8'h02);
      chk($sformatf("t1_od[%0d]", i), log_od[i], 8'h10 + 8'(i));
    end
    chk("t1_bubbles", bubbles, 1);
    chk("t1_illegal", illegal, 0);
    #1;
    chk("t1_sel_last", sel, 3'd1);
    chk("t1_busy_end", busy, 1'b0);

    // en_mask=0x84: grants alternate 2,7,2,7
    reset_dut();
    en_mask   = 8'h84;
    out_ready = 8'hFF;
    run_stream(16, 8'h20, 16, 8'h84);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_ov[%0d]", i), log_ov[i], ((i / 4) % 2 == 0) ? 8'h04 : 8'h80);
      chk($sformatf("t2_od[%0d]", i), log_od[i], 8'h20 + 8'(i));
    end
    chk("t2_bubbles", bubbles, 3);
    chk("t2_illegal", illegal, 0);

    // Dest 3 stalls for 5 cycles mid-burst
    reset_dut();
    en_mask   = 8'h08;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    in_data   = 8'h30;
    tick();
    in_data = 8'h31;
    tick();
    #1;
    chk("t3_sel", sel, 3'd3);
    chk("t3_ov_first", out_valid, 8'h08);
    chk("t3_od_first", out_data, 8'h30);
    tick();
    out_ready = 8'hF7;
    in_data   = 8'h32;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (out_valid !== 8'h08 || out_data !== 8'h31 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
      tick();
    end
    chk("t3_stall_cycles_bad", bad, 0);
    out_ready = 8'hFF;
    run_stream(2, 8'h32, 3, 8'h08);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_ov[%0d]", i), log_ov[i], 8'h08);
      chk($sformatf("t3_od[%0d]", i), log_od[i], 8'h31 + 8'(i));
    end
    #1;
    chk("t3_busy_end", busy, 1'b0);
    chk("t3_in_ready_end", in_ready, 1'b1);

    // Disable dest 5 while it holds a stalled word; word moves to dest 6
    reset_dut();
    en_mask   = 8'h60;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    in_data   = 8'h50;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 8'hDF;
    #1;
    chk("t4_sel5", sel, 3'd5);
    chk("t4_ov5", out_valid, 8'h20);
    tick();
    en_mask = 8'h40;
    #1;
    chk("t4_ov5_held", out_valid, 8'h20);
    tick();
    #1;
    chk("t4_idle_busy", busy, 1'b0);
    chk("t4_idle_ov", out_valid, 8'h00);
    tick();
    #1;
    chk("t4_sel6", sel, 3'd6);
    chk("t4_ov6", out_valid, 8'h40);
    chk("t4_od6", out_data, 8'h50);
    tick();
    #1;
    chk("t4_empty_ov", out_valid, 8'h00);
    chk("t4_empty_busy", busy, 1'b1);

    // Asynchronous reset mid-burst with a buffered word
    reset_dut();
    en_mask   = 8'h10;
    out_ready = 8'h10;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 8'h00;
    #1;
    chk("t5_pre_ov", out_valid, 8'h10);
    chk("t5_pre_sel", sel, 3'd4);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_async_ov", out_valid, 8'h00);
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_in_ready", in_ready, 1'b1);
    chk("t5_async_sel", sel, 3'd0);
    chk("t5_async_od", out_data, 8'h00);
    #1;
    rst = 1'b0;
    tick();
    en_mask   = 8'hFF;
    out_ready = 8'hFF;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    tick();
    in_valid = 1'b0;
    tick();
    #1;
    chk("t5_first_grant_ov", out_valid, 8'h01);
    chk("t5_first_grant_od", out_data, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
